// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for MULT/MULTU/DIV/DIVU and MTHI/MTLO; owns HI/LO.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start_i, op_i   : op request from EX (held while stall_o is high)
//   a_i, b_i        : rs / rt operands
//   hilo_rd_i       : MFHI/MFLO in EX (never needs an extra stall here)
//   flush_i         : aborts the op in flight, blocks acceptance in IDLE
//   stall_o, busy_o : pipeline freeze, FSM in BUSY
//   done_o          : one-cycle pulse, HI/LO written at the end of this cycle
//   hi_o, lo_o      : architectural HI/LO
// Handshake: an op is taken when IDLE & start_i & !flush_i; while stall_o is
// high, EX keeps presenting the same op. In the done_o cycle stall_o is low,
// so EX advances on that edge and any start_i seen afterwards in IDLE is new.
module muldiv_ctrl #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        hilo_rd_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        sgn_q, sgn_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;   // dividend / quotient (div) or multiplicand (mul)
   logic [31:0] dvs_q, dvs_d;   // divisor (div) or multiplier (mul)
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        op_md, op_mt, accept, mt_wr, last;
   logic        op_signed;
   logic [31:0] a_abs, b_abs;
   logic [32:0] shifted, diff;
   logic [31:0] step_rem, step_quo, div_hi, div_lo;
   logic [63:0] a64, b64, prod;

   // MFHI/MFLO never needs its own stall: while BUSY the op already stalls,
   // and once done_o has fired HI/LO are updated for the following cycle.
   logic unused_hilo_rd;
   assign unused_hilo_rd = hilo_rd_i;

   assign op_md     = start_i && !op_i[2];
   assign op_mt     = start_i && (op_i[2:1] == 2'b10);
   assign accept    = (state_q == IDLE) && op_md && !flush_i;
   assign mt_wr     = (state_q == IDLE) && op_mt && !flush_i;
   assign last      = (state_q == BUSY) && (cnt_q == 5'd0) && !flush_i;
   assign op_signed = !op_i[0];
   assign a_abs     = (op_signed && a_i[31]) ? -a_i : a_i;
   assign b_abs     = (op_signed && b_i[31]) ? -b_i : b_i;

   // One restoring-divide iteration: shift the next dividend bit into the
   // remainder and subtract when it fits.
   assign shifted  = {rem_q, quo_q[31]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
   assign step_quo = {quo_q[30:0], ~diff[32]};
   // A zero divisor already leaves the remainder equal to a; only the
   // quotient needs forcing so the sign fix-up cannot turn it into 1.
   assign div_lo   = (dvs_q == 32'd0) ? 32'hFFFF_FFFF :
                     (q_neg_q ? -step_quo : step_quo);
   assign div_hi   = r_neg_q ? -step_rem : step_rem;

   // The low 64 bits of a 64x64 product of sign/zero-extended operands are
   // the correct result for both MULT and MULTU.
   assign a64  = {{32{sgn_q & quo_q[31]}}, quo_q};
   assign b64  = {{32{sgn_q & dvs_q[31]}}, dvs_q};
   assign prod = a64 * b64;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         sgn_q    <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         dvs_q    <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sgn_q    <= sgn_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sgn_d    = sgn_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = BUSY;
               is_div_d = op_i[1];
               sgn_d    = op_signed;
               rem_d    = 32'd0;
               if (op_i[1]) begin
                  cnt_d   = 5'd31;
                  quo_d   = a_abs;
                  dvs_d   = b_abs;
                  q_neg_d = op_signed && (a_i[31] ^ b_i[31]);
                  r_neg_d = op_signed && a_i[31];
               end else begin
                  cnt_d   = 5'(MUL_LAT - 1);
                  quo_d   = a_i;
                  dvs_d   = b_i;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
               end
            end else if (mt_wr) begin
               if (op_i[0]) lo_d = a_i;
               else         hi_d = a_i;
            end
         end
         BUSY: begin
            if (flush_i) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q - 5'd1;
               if (is_div_q) begin
                  rem_d = step_rem;
                  quo_d = step_quo;
               end
               if (cnt_q == 5'd0) begin
                  state_d = IDLE;
                  cnt_d   = 5'd0;
                  hi_d    = is_div_q ? div_hi : prod[63:32];
                  lo_d    = is_div_q ? div_lo : prod[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low while rst is asserted so a request still held
   // by EX cannot show through during reset.
   always_comb begin
      busy_o  = (state_q == BUSY);
      stall_o = !rst && (accept || ((state_q == BUSY) && (cnt_q != 5'd0) && !flush_i));
      done_o  = !rst && (mt_wr || last);
      hi_o    = hi_q;
      lo_o    = lo_q;
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

   localparam int MUL_LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'b000;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        hilo_rd_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        stall_o, busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .hilo_rd_i(hilo_rd_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
      .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op at posedge+1 (cycle 0), watch stall/done on negedges,
   // then release start (unless hold) and check HI/LO the cycle after done.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit hold);
      int done_c = -1;
      int stall_n = 0;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall_o) stall_n++;
         if (done_o) begin
            done_c = c;
            break;
         end
      end
      chk({tag, "_done_cycle"}, 64'(done_c), 64'(lat));
      chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(lat));
      if (!hold) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         @(negedge clk);
         chk({tag, "_hi"}, 64'(hi_o), 64'(ehi));
         chk({tag, "_lo"}, 64'(lo_o), 64'(elo));
         chk({tag, "_idle"}, 64'(busy_o), 64'd0);
      end
   endtask

   initial begin
      int done_seen;
      // reset state
      #2;
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1: MULTU max*max
      @(posedge clk); #1;
      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

      // MFHI in the cycle after done: no stall
      @(posedge clk); #1 hilo_rd_i = 1'b1;
      @(negedge clk);
      chk("hilo_rd_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1 hilo_rd_i = 1'b0;

      // 2: signed divide -7 / 2
      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      @(posedge clk); #1;
      run_op("div_pos_negb", 3'b010, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 32'hFFFF_FFFD, 1'b0);
      @(posedge clk); #1;
      run_op("divu", 3'b011, 32'd100, 32'd7, 32, 32'd2, 32'd14, 1'b0);

      // 3: divide by zero and the overflow case
      @(posedge clk); #1;
      run_op("divu_zero", 3'b011, 32'h1234_5678, 32'd0, 32, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk); #1;
      run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF9, 32'd0, 32, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk); #1;
      run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000, 1'b0);

      // 4: preset HI/LO, then flush a DIV in cycle 10
      @(posedge clk); #1;
      run_op("mthi", 3'b100, 32'hAAAA_0000, 32'd0, 0, 32'hAAAA_0000, 32'h8000_0000, 1'b0);
      @(posedge clk); #1;
      run_op("mtlo", 3'b101, 32'h0000_BBBB, 32'd0, 0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b010; a_i = 32'd100; b_i = 32'd3;
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1;
      @(negedge clk);
      chk("flush_stall", 64'(stall_o), 64'd0);
      chk("flush_done", 64'(done_o), 64'd0);
      chk("flush_busy_before", 64'(busy_o), 64'd1);
      @(posedge clk); #1;
      flush_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      chk("flush_idle", 64'(busy_o), 64'd0);
      done_seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done_o) done_seen++;
      end
      chk("flush_no_done", 64'(done_seen), 64'd0);
      chk("flush_hi", 64'(hi_o), 64'h0000_0000_AAAA_0000);
      chk("flush_lo", 64'(lo_o), 64'h0000_0000_0000_BBBB);

      // flush in IDLE blocks MTHI; illegal op is ignored
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b100; a_i = 32'hDEAD_BEEF; flush_i = 1'b1;
      @(negedge clk);
      chk("flush_mthi_done", 64'(done_o), 64'd0);
      @(posedge clk); #1;
      op_i = 3'b110; flush_i = 1'b0;
      @(negedge clk);
      chk("illegal_stall", 64'(stall_o), 64'd0);
      chk("illegal_done", 64'(done_o), 64'd0);
      @(posedge clk); #1 start_i = 1'b0;
      @(negedge clk);
      chk("illegal_busy", 64'(busy_o), 64'd0);
      chk("flush_mthi_hi", 64'(hi_o), 64'h0000_0000_AAAA_0000);

      // 5: MULT -2*3 then MTLO 5 queued behind it
      @(posedge clk); #1;
      run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'd0, 32'd0, 1'b1);
      @(posedge clk); #1;
      op_i = 3'b101; a_i = 32'd5;
      @(negedge clk);
      chk("mtlo_after_done", 64'(done_o), 64'd1);
      chk("mtlo_after_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1 start_i = 1'b0;
      @(negedge clk);
      chk("mult_mtlo_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
      chk("mult_mtlo_lo", 64'(lo_o), 64'd5);

      // 6: async reset mid-DIV, then MULT 3*4
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b010; a_i = 32'd1000; b_i = 32'd7;
      repeat (15) @(posedge clk);
      #2 rst = 1'b1; start_i = 1'b0;
      #1;
      chk("arst_hi", 64'(hi_o), 64'd0);
      chk("arst_lo", 64'(lo_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_stall", 64'(stall_o), 64'd0);
      chk("arst_done", 64'(done_o), 64'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      run_op("mult_small", 3'b000, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
